mac_tx_arbiter: RTL and testbench
=================================

# mac_tx_arbiter

Parametrised N-channel transmit arbiter between frame sources (ARP, IP, future VLAN/PTP generators) and the single `mac_tx` framer. Generalises the fixed two-way ARP/IP selection to NUM_CH sources with selectable round-robin or fixed-priority arbitration. It owns the req/ack handshake with `mac_tx` and holds a grant until `mac_send_end`. A watchdog releases a stalled grant.

## Interface
Parameters:
- NUM_CH, 4: number of source channels, 2..16
- DW, 8: data width per channel
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (ch0 highest)
- TIMEOUT, 65535: watchdog limit in cycles, 0 = watchdog disabled; counter is 16 bits

Ports (CW = max(1, clog2(NUM_CH))):
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- src_tx_req  in  NUM_CH  per-source frame request, level, held until acked
- src_tx_ack  out  NUM_CH  one-cycle grant pulse to the selected source
- src_tx_ready  in  NUM_CH  per-source data valid
- src_tx_data  in  NUM_CH*DW  per-source data; channel k at [k*DW +: DW]
- src_tx_end  in  NUM_CH  per-source last-byte flag
- mac_tx_req  out  1  request to `mac_tx`
- mac_tx_ack  in  1  acceptance pulse from `mac_tx`
- mac_tx_ready  out  1  muxed data valid
- mac_tx_data  out  DW  muxed data
- mac_tx_end  out  1  muxed last-byte flag
- mac_send_end  in  1  pulse from `mac_tx`: frame including FCS fully sent
- grant_ch  out  CW  currently or last granted channel
- busy  out  1  high from the ARB cycle through DONE
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, ARB, REQ, SEND, DONE.
- IDLE: when any `src_tx_req` is high, go to ARB.
- ARB: select the winner.
  - Round-robin: search starts at `rr_ptr`. The lowest index at or above `rr_ptr` with req high wins, wrapping modulo NUM_CH.
  - Fixed priority: the lowest index wins.
  - Register `grant_ch` and go to REQ. If all requests have dropped, return to IDLE.
- REQ: drive `mac_tx_req` high. On `mac_tx_ack`, pulse `src_tx_ack[grant_ch]` for exactly one cycle, drop `mac_tx_req`, and go to SEND.
- SEND: forward the stream of channel `grant_ch`:
  - `mac_tx_ready`, `mac_tx_data` and `mac_tx_end` come from that channel.
  - Non-granted inputs are ignored.
  - Outputs are forced to 0 in every state other than SEND.
  - On `mac_send_end`, go to DONE.
- DONE: one cycle, idle gap.
  - Round-robin: set `rr_ptr` = (grant_ch+1) mod NUM_CH.
  - Then go to IDLE.
- Watchdog (TIMEOUT ≠ 0):
  - A 16-bit counter clears on entry to REQ and on entry to SEND, and increments each cycle in REQ/SEND.
  - When the count equals TIMEOUT-1: pulse `timeout_err`, deassert all outputs, advance `rr_ptr` as in DONE, and go to IDLE.
  - Any in-flight `mac_send_end` is then ignored.
- Boundary behaviour:
  - `mac_send_end` outside SEND is ignored.
  - `mac_tx_ack` outside REQ is ignored.
  - A new request arriving during SEND is only considered after DONE.
  - A source that drops its req during REQ does not abort the frame; the grant stands until end or timeout.
  - If `mac_tx_ack` and the watchdog expiry occur in the same cycle, the ack wins.
  - If `mac_send_end` and the watchdog expiry occur in the same cycle, end wins and there is no `timeout_err`.

## Timing
- Reset (async assert, sync release): state=IDLE, `rr_ptr`=0, `grant_ch`=0, and every output is 0.
- Arbitration latency: a request seen in IDLE at cycle t gives ARB at t+1 and `mac_tx_req` high at t+2.
- `src_tx_ack` is registered: it is high the cycle after `mac_tx_ack` is sampled, and `mac_tx_req` is low in that same cycle.
- The data path is combinational in SEND: zero-cycle latency from `src_tx_*` to `mac_tx_*`. No buffering; sources must obey `mac_tx` pacing.
- `busy` is registered. It rises with ARB and falls on entry to IDLE.
- Minimum spacing between consecutive frames: the DONE cycle plus IDLE, ARB and REQ, so at least 4 cycles from `mac_send_end` to the next `mac_tx_req`.
- Reset asserted mid-frame drops all outputs immediately, asynchronously.

## Test plan
- Single source: ch2 req, `mac_tx` acks after 3 cycles, 60-byte stream → `mac_tx_req` at t+2, `src_tx_ack[2]` a one-cycle pulse, 60 bytes forwarded unchanged, `grant_ch`=2, `busy` low 2 cycles after `mac_send_end`.
- Round-robin, NUM_CH=4, all reqs held high for 8 frames → grant order 0,1,2,3,0,1,2,3.
- PRIO_MODE=1, ch1 and ch3 requesting continuously → ch1 granted every frame; ch3 granted only after ch1 drops its req.
- Watchdog TIMEOUT=100, `mac_tx_ack` never arrives → `timeout_err` pulses 100 cycles after REQ entry, `mac_tx_req` drops, and the next channel is arbitrated.
- Same-cycle events: `mac_send_end` coincides with watchdog expiry → no `timeout_err`, normal DONE. Non-granted channel toggling ready/data during SEND → `mac_tx_*` unaffected.
- `rst_n` pulled low mid-SEND → all outputs 0 in the same cycle; after release, state is IDLE and `rr_ptr`=0.

Source files
------------

// File: rtl/mac_tx_arbiter_if.sv
// Bundle of source-side and mac_tx-side signals for the transmit arbiter.
// The arbiter attaches through the slave modport; the environment (sources,
// mac_tx framer, status consumers) attaches through the master modport.
interface mac_tx_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int DW     = 8
);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // source side
   logic [NUM_CH-1:0]    src_tx_req;
   logic [NUM_CH-1:0]    src_tx_ack;
   logic [NUM_CH-1:0]    src_tx_ready;
   logic [NUM_CH*DW-1:0] src_tx_data;
   logic [NUM_CH-1:0]    src_tx_end;

   // mac_tx side
   logic                 mac_tx_req;
   logic                 mac_tx_ack;
   logic                 mac_tx_ready;
   logic [DW-1:0]        mac_tx_data;
   logic                 mac_tx_end;
   logic                 mac_send_end;

   // status
   logic [CW-1:0]        grant_ch;
   logic                 busy;
   logic                 timeout_err;

   modport slave (
      input  src_tx_req, src_tx_ready, src_tx_data, src_tx_end,
      input  mac_tx_ack, mac_send_end,
      output src_tx_ack, mac_tx_req, mac_tx_ready, mac_tx_data, mac_tx_end,
      output grant_ch, busy, timeout_err
   );

   modport master (
      output src_tx_req, src_tx_ready, src_tx_data, src_tx_end,
      output mac_tx_ack, mac_send_end,
      input  src_tx_ack, mac_tx_req, mac_tx_ready, mac_tx_data, mac_tx_end,
      input  grant_ch, busy, timeout_err
   );
endinterface

// File: rtl/mac_tx_arbiter.sv
// N-channel transmit arbiter in front of the single mac_tx framer.
// Selects one source (round-robin or fixed priority), runs the req/ack
// handshake with mac_tx, forwards the granted stream combinationally until
// mac_send_end, and releases a stalled grant through a 16-bit watchdog.
module mac_tx_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int DW        = 8,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 65535
) (
   input  logic           clk,
   input  logic           rst_n,
   mac_tx_arbiter_if.slave bus
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARB  = 3'd1;
   localparam logic [2:0] S_REQ  = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [CW:0]   NCH_W    = (CW+1)'(NUM_CH);
   localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
   localparam logic [15:0]   WD_LIMIT = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
   localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

   // state and registered outputs
   logic [2:0]        r_state;
   logic [CW-1:0]     r_rr_ptr;
   logic [CW-1:0]     r_grant;
   logic [NUM_CH-1:0] r_src_ack;
   logic              r_busy;
   logic              r_tout;
   logic [15:0]       r_wd;

   // arbitration
   logic              w_found;
   logic [CW-1:0]     w_win;
   logic [CW:0]       w_sum;
   logic [CW-1:0]     w_idx;
   logic [CW-1:0]     w_ptr_adv;
   logic              w_expire;

   // data path
   logic [DW-1:0]     w_ch_data [NUM_CH];
   logic              w_ready;
   logic [DW-1:0]     w_data;
   logic              w_end;

   // split the flat data bus into per-channel words
   for (genvar g = 0; g < NUM_CH; g++) begin : g_split
      assign w_ch_data[g] = bus.src_tx_data[g*DW +: DW];
   end

   // winner search: rotate from rr_ptr (round-robin) or from ch0 (priority)
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (PRIO_MODE != 0) begin
            w_idx = CW'(i);
         end else begin
            w_sum = {1'b0, r_rr_ptr} + (CW+1)'(i);
            if (w_sum >= NCH_W) begin
               w_sum = w_sum - NCH_W;
            end
            w_idx = w_sum[CW-1:0];
         end
         if (!w_found && bus.src_tx_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   // next round-robin start point and watchdog expiry
   always_comb begin
      w_ptr_adv = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;
      w_expire  = (TIMEOUT != 0) && (r_wd == WD_LIMIT);
   end

   // granted-channel stream forwarding, forced to zero outside SEND
   always_comb begin
      w_ready = 1'b0;
      w_data  = '0;
      w_end   = 1'b0;
      if (r_state == S_SEND) begin
         w_ready = bus.src_tx_ready[r_grant];
         w_data  = w_ch_data[r_grant];
         w_end   = bus.src_tx_end[r_grant];
      end
   end

   // arbiter FSM, handshake pulses and watchdog counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_src_ack <= '0;
         r_busy    <= 1'b0;
         r_tout    <= 1'b0;
         r_wd      <= '0;
      end else begin
         r_src_ack <= '0;
         r_tout    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|bus.src_tx_req) begin
                  r_state <= S_ARB;
                  r_busy  <= 1'b1;
               end
            end
            S_ARB: begin
               if (w_found) begin
                  r_grant <= w_win;
                  r_wd    <= '0;
                  r_state <= S_REQ;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_REQ: begin
               // ack takes precedence over a simultaneous watchdog expiry
               if (bus.mac_tx_ack) begin
                  r_src_ack <= ONE_HOT0 << r_grant;
                  r_wd      <= '0;
                  r_state   <= S_SEND;
               end else if (w_expire) begin
                  r_tout  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  if (PRIO_MODE == 0) begin
                     r_rr_ptr <= w_ptr_adv;
                  end
               end else begin
                  r_wd <= r_wd + 16'd1;
               end
            end
            S_SEND: begin
               // end of frame takes precedence over a simultaneous expiry
               if (bus.mac_send_end) begin
                  r_state <= S_DONE;
               end else if (w_expire) begin
                  r_tout  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  if (PRIO_MODE == 0) begin
                     r_rr_ptr <= w_ptr_adv;
                  end
               end else begin
                  r_wd <= r_wd + 16'd1;
               end
            end
            S_DONE: begin
               if (PRIO_MODE == 0) begin
                  r_rr_ptr <= w_ptr_adv;
               end
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.src_tx_ack   = r_src_ack;
   assign bus.mac_tx_req   = (r_state == S_REQ);
   assign bus.mac_tx_ready = w_ready;
   assign bus.mac_tx_data  = w_data;
   assign bus.mac_tx_end   = w_end;
   assign bus.grant_ch     = r_grant;
   assign bus.busy         = r_busy;
   assign bus.timeout_err  = r_tout;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: one round-robin and one fixed-priority
// instance (both TIMEOUT=100) driven by the same source/mac_tx stimulus.
module tb_mac_tx_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req   = '0;
   logic [3:0]  rdy   = '0;
   logic [3:0]  tend  = '0;
   logic [31:0] dat   = '0;
   logic        mack  = 1'b0;
   logic        msend = 1'b0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   mac_tx_arbiter_if #(.NUM_CH(NCH), .DW(DW)) ifa ();
   mac_tx_arbiter_if #(.NUM_CH(NCH), .DW(DW)) ifb ();

   assign ifa.src_tx_req   = req;
   assign ifa.src_tx_ready = rdy;
   assign ifa.src_tx_data  = dat;
   assign ifa.src_tx_end   = tend;
   assign ifa.mac_tx_ack   = mack;
   assign ifa.mac_send_end = msend;
   assign ifb.src_tx_req   = req;
   assign ifb.src_tx_ready = rdy;
   assign ifb.src_tx_data  = dat;
   assign ifb.src_tx_end   = tend;
   assign ifb.mac_tx_ack   = mack;
   assign ifb.mac_send_end = msend;

   mac_tx_arbiter #(.NUM_CH(NCH), .DW(DW), .PRIO_MODE(0), .TIMEOUT(100)) u_rr (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   mac_tx_arbiter #(.NUM_CH(NCH), .DW(DW), .PRIO_MODE(1), .TIMEOUT(100)) u_fp (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // all outputs of the round-robin instance packed together
   function automatic logic [31:0] outs_a();
      return {8'd0, ifa.mac_tx_data, ifa.src_tx_ack, 2'(ifa.grant_ch),
              ifa.mac_tx_req, ifa.mac_tx_ready, ifa.mac_tx_end,
              ifa.busy, ifa.timeout_err, 3'd0};
   endfunction

   // bounded wait for mac_tx_req; returns in the first REQ cycle
   task automatic wait_req(input string tag);
      int unsigned n = 0;
      while (ifa.mac_tx_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "/req_seen"}, 32'(ifa.mac_tx_req), 32'd1);
   endtask

   // one complete frame with immediate ack; returns in IDLE after DONE
   task automatic frame(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
      wait_req(tag);
      mack = 1'b1;
      tick();
      mack = 1'b0;
      check({tag, "/grant_rr"}, 32'(ifa.grant_ch), 32'(exp_a));
      check({tag, "/ack_rr"},   32'(ifa.src_tx_ack), 32'(4'b0001 << exp_a));
      check({tag, "/grant_fp"}, 32'(ifb.grant_ch), 32'(exp_b));
      msend = 1'b1;
      tick();
      msend = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got stalled, expected completion");
      $fatal(1);
   end

   initial begin
      // reset state
      #12;
      check("rst/outs_rr", outs_a(), 32'd0);
      check("rst/busy_fp", 32'(ifb.busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst/idle_rr", outs_a(), 32'd0);

      // single source ch2: latency, ack pulse, 60-byte stream, busy tail
      req = 4'b0100;
      tick();
      check("s2/arb_busy", 32'(ifa.busy), 32'd1);
      check("s2/arb_noreq", 32'(ifa.mac_tx_req), 32'd0);
      tick();
      check("s2/req_t2", 32'(ifa.mac_tx_req), 32'd1);
      check("s2/grant", 32'(ifa.grant_ch), 32'd2);
      tick();
      tick();
      check("s2/req_hold", 32'(ifa.mac_tx_req), 32'd1);
      mack = 1'b1;
      tick();
      mack = 1'b0;
      req  = 4'b0000;
      check("s2/ack_pulse", 32'(ifa.src_tx_ack), 32'h4);
      check("s2/req_drop", 32'(ifa.mac_tx_req), 32'd0);
      for (int b = 0; b < 60; b++) begin
         rdy  = {1'($urandom), 1'b1, 1'($urandom), 1'($urandom)};
         dat  = {8'($urandom), 8'(b*7 + 3), 16'($urandom)};
         tend = {1'($urandom), (b == 59), 2'($urandom)};
         #1;
         check("s2/byte", 32'({ifa.mac_tx_end, ifa.mac_tx_ready, ifa.mac_tx_data}),
               32'({(b == 59), 1'b1, 8'(b*7 + 3)}));
         if (b == 1) check("s2/ack_once", 32'(ifa.src_tx_ack), 32'd0);
         tick();
      end
      rdy = '0; dat = '0; tend = '0;
      msend = 1'b1;
      tick();
      msend = 1'b0;
      check("s2/done_busy", 32'(ifa.busy), 32'd1);
      rdy = 4'b0100;
      #1;
      check("s2/done_zero", 32'(ifa.mac_tx_ready), 32'd0);
      tick();
      rdy = '0;
      check("s2/idle_busy", 32'(ifa.busy), 32'd0);

      // round-robin order with all requests held high
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req = 4'hF;
      for (int f = 0; f < 8; f++) frame("rr", 2'(f % 4), 2'd0);

      // ch1 and ch3 requesting; then ch1 drops
      req = 4'b1010;
      frame("fp1", 2'd1, 2'd1);
      frame("fp2", 2'd3, 2'd1);
      frame("fp3", 2'd1, 2'd1);
      req = 4'b1000;
      frame("fp4", 2'd3, 2'd3);

      // end of frame coincides with watchdog expiry; other channels toggle
      req = 4'b0001;
      wait_req("co");
      mack = 1'b1;
      tick();
      mack = 1'b0;
      req  = '0;
      for (int k = 0; k < 99; k++) begin
         rdy  = {3'($urandom), 1'b1};
         dat  = {24'($urandom), 8'h5A};
         tend = {3'($urandom), 1'b0};
         #1;
         check("co/iso", 32'({ifa.mac_tx_end, ifa.mac_tx_ready, ifa.mac_tx_data}), 32'h15A);
         tick();
      end
      rdy = '0; dat = '0; tend = '0;
      msend = 1'b1;
      tick();
      msend = 1'b0;
      check("co/no_tout", 32'(ifa.timeout_err), 32'd0);
      check("co/done_busy", 32'(ifa.busy), 32'd1);
      tick();
      check("co/idle", 32'({ifa.busy, ifa.timeout_err}), 32'd0);

      // watchdog expiry in SEND; late end is ignored
      req = 4'b0001;
      wait_req("ws");
      mack = 1'b1;
      tick();
      mack = 1'b0;
      req  = '0;
      for (int k = 0; k < 99; k++) tick();
      check("ws/not_yet", 32'(ifa.timeout_err), 32'd0);
      tick();
      check("ws/tout", 32'(ifa.timeout_err), 32'd1);
      check("ws/busy", 32'(ifa.busy), 32'd0);
      msend = 1'b1;
      tick();
      msend = 1'b0;
      check("ws/pulse", 32'(ifa.timeout_err), 32'd0);
      tick();
      check("ws/late_end", 32'(ifa.busy), 32'd0);

      // ack coinciding with expiry in REQ wins
      req = 4'b0001;
      wait_req("aw");
      for (int k = 0; k < 99; k++) tick();
      check("aw/still_req", 32'(ifa.mac_tx_req), 32'd1);
      mack = 1'b1;
      tick();
      mack = 1'b0;
      req  = '0;
      check("aw/no_tout", 32'(ifa.timeout_err), 32'd0);
      check("aw/ack", 32'(ifa.src_tx_ack), 32'h1);
      msend = 1'b1;
      tick();
      msend = 1'b0;
      tick();

      // REQ stall: no ack, timeout releases, next channel arbitrated
      req = 4'b0110;
      wait_req("wr");
      check("wr/grant_rr", 32'(ifa.grant_ch), 32'd1);
      for (int k = 0; k < 100; k++) tick();
      check("wr/tout", 32'(ifa.timeout_err), 32'd1);
      check("wr/req_drop", 32'(ifa.mac_tx_req), 32'd0);
      mack = 1'b1;
      tick();
      mack = 1'b0;
      check("wr/pulse", 32'(ifa.timeout_err), 32'd0);
      tick();
      check("wr/rearb_req", 32'(ifa.mac_tx_req), 32'd1);
      check("wr/next_rr", 32'(ifa.grant_ch), 32'd2);
      check("wr/next_fp", 32'(ifb.grant_ch), 32'd1);
      check("wr/stray_ack", 32'(ifa.src_tx_ack), 32'd0);
      mack = 1'b1;
      tick();
      mack = 1'b0;
      check("wr/ack", 32'(ifa.src_tx_ack), 32'h4);

      // reset mid-SEND clears everything immediately
      rdy  = 4'b0100;
      dat  = 32'h0077_0000;
      tend = 4'b0100;
      #1;
      check("rs/fwd", 32'({ifa.mac_tx_end, ifa.mac_tx_ready, ifa.mac_tx_data}), 32'h377);
      rst_n = 1'b0;
      #1;
      check("rs/async_zero", outs_a(), 32'd0);
      check("rs/busy_fp", 32'(ifb.busy), 32'd0);
      rdy = '0; dat = '0; tend = '0; req = '0;
      tick();
      rst_n = 1'b1;
      tick();
      req = 4'hF;
      frame("rs_ptr", 2'd0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
